// File: rtl/wb_engine_pkg.sv
// ----------------------------------------------------------------------------
// wb_engine_pkg
// Shared definitions for the Wishbone-style initiator that drives the
// two-engine accelerator slave port.
//   - FSM state encoding of the bus master
//   - slave register map (ID, result, weight and feature addresses)
//   - expected ID register contents
//   - command word layout {we, addr, data} and a helper that packs it
// ----------------------------------------------------------------------------
package wb_engine_pkg;

   // Bus master FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WR   = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   // Slave register map
   localparam logic [7:0] ADDR_ID0          = 8'h81;
   localparam logic [7:0] ADDR_ID1          = 8'h82;
   localparam logic [7:0] ADDR_ID2          = 8'h83;
   localparam logic [7:0] ADDR_RESULT       = 8'hA0;
   localparam logic [7:0] ADDR_W0_LO        = 8'h51;
   localparam logic [7:0] ADDR_W0_MID       = 8'h52;
   localparam logic [7:0] ADDR_W0_HI        = 8'h53;
   localparam logic [7:0] ADDR_W1_LO        = 8'h54;
   localparam logic [7:0] ADDR_W1_MID       = 8'h55;
   localparam logic [7:0] ADDR_W1_HI        = 8'h56;
   localparam logic [7:0] ADDR_FEATURE_BASE = 8'hC0;  // 0xC0..0xCF

   // Contents of the read-only ID registers
   localparam logic [31:0] ID0_VAL = 32'h414D_5331;
   localparam logic [31:0] ID1_VAL = 32'h4345_4149;
   localparam logic [31:0] ID2_VAL = 32'h322E_3030;

   // One buffered command
   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);  // 41

   function automatic cmd_t make_cmd(input logic we, input logic [7:0] addr,
                                     input logic [31:0] data);
      cmd_t c;
      c.we   = we;
      c.addr = addr;
      c.data = data;
      return c;
   endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// ----------------------------------------------------------------------------
// wb_cmd_fifo
// Synchronous first-word-fall-through FIFO for initiator commands.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data write request; ignored while full (even if popping)
//   pop, pop_data   read request; pop_data always shows the head entry
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module wb_cmd_fifo
   import wb_engine_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = CMD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // full/empty come from the registered count only, so a push while full
   // is refused even when a pop frees a slot in the same cycle.
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_engine_master.sv
// ----------------------------------------------------------------------------
// wb_engine_master
// Wishbone-style initiator for the two-engine accelerator slave port.
// Commands are buffered in a small FIFO and issued one at a time; each
// accepted command produces exactly one response, in order.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_we, cmd_addr, cmd_data       command (data ignored for reads)
//   rsp_valid                        one-cycle completion pulse
//   rsp_we, rsp_err, rsp_data        completion info, held until next response
//   wb_cyc, wb_str, wb_we            bus control (0 whenever the bus is idle)
//   wb_addr, wb_dat_o                bus address / write data (hold last value)
//   wb_dat_i, wb_ack                 slave read data / write acknowledge
//   busy                             FIFO non-empty or transaction in flight
//
// Handshake: a command is transferred on a rising clk edge where
// cmd_valid && cmd_ready are both 1; cmd_ready depends only on registered
// FIFO occupancy, and the command inputs must be stable while cmd_valid=1.
// ----------------------------------------------------------------------------
module wb_engine_master
   import wb_engine_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int READ_LAT   = 1,
   parameter int TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [7:0]  cmd_addr,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   output logic        rsp_we,
   output logic        rsp_err,
   output logic [31:0] rsp_data,
   output logic        wb_cyc,
   output logic        wb_str,
   output logic        wb_we,
   output logic [7:0]  wb_addr,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack,
   output logic        busy
);

   // The same counter times write strobes (up to TIMEOUT) and read
   // strobes (READ_LAT+1), so it is sized for the larger of the two.
   localparam int CNT_MAX = (TIMEOUT > READ_LAT + 1) ? TIMEOUT : READ_LAT + 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int FC_W    = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;

   logic             fifo_full;
   logic             fifo_empty;
   logic [FC_W-1:0]  fifo_count;
   logic [CMD_W-1:0] fifo_head_raw;
   cmd_t             head;
   logic             fifo_pop;

   assign head      = cmd_t'(fifo_head_raw);
   assign cmd_ready = !fifo_full;
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
   assign busy      = (fifo_count != '0) || (state != ST_IDLE);

   wb_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cmd_valid),
      .push_data (make_cmd(cmd_we, cmd_addr, cmd_data)),
      .pop       (fifo_pop),
      .pop_data  (fifo_head_raw),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         wb_cyc    <= 1'b0;
         wb_str    <= 1'b0;
         wb_we     <= 1'b0;
         wb_addr   <= '0;
         wb_dat_o  <= '0;
         rsp_valid <= 1'b0;
         rsp_we    <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  wb_addr  <= head.addr;
                  wb_dat_o <= head.data;
                  wb_we    <= head.we;
                  wb_cyc   <= 1'b1;
                  wb_str   <= 1'b1;
                  cnt      <= '0;
                  state    <= head.we ? ST_WR : ST_RD;
               end
            end
            ST_WR: begin
               // An ack on the final allowed cycle still counts as success.
               if (wb_ack || (cnt == CNT_W'(TIMEOUT - 1))) begin
                  rsp_valid <= 1'b1;
                  rsp_we    <= 1'b1;
                  rsp_err   <= !wb_ack;
                  rsp_data  <= '0;
                  wb_cyc    <= 1'b0;
                  wb_str    <= 1'b0;
                  wb_we     <= 1'b0;
                  state     <= ST_GAP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_RD: begin
               // The slave registers read data, so it is valid READ_LAT
               // cycles after the first strobe cycle.
               if (cnt == CNT_W'(READ_LAT)) begin
                  rsp_valid <= 1'b1;
                  rsp_we    <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_data  <= wb_dat_i;
                  wb_cyc    <= 1'b0;
                  wb_str    <= 1'b0;
                  wb_we     <= 1'b0;
                  state     <= ST_GAP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               // One dead cycle so the slave's write pulse and read
               // register clear between transactions.
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_engine_master.sv
// ----------------------------------------------------------------------------
// tb_wb_engine_master
// Self-checking bench for wb_engine_master. A behavioural accelerator slave
// (ack on writes, registered read data) sits on the bus. Each accepted
// command pushes its expected bus transaction and expected response into
// queues; a negedge monitor pops and compares them as the DUT produces them.
// The slave's RESULT register is {outb, outa}: outa is the 16-bit sum of the
// low halves of features 0..7, outb the same over features 8..15.
// ----------------------------------------------------------------------------
module tb_wb_engine_master;
   import wb_engine_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int READ_LAT   = 1;
   localparam int TIMEOUT    = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_we;
   logic        rsp_err;
   logic [31:0] rsp_data;
   logic        wb_cyc;
   logic        wb_str;
   logic        wb_we;
   logic [7:0]  wb_addr;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack;
   logic        busy;

   wb_engine_master #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .READ_LAT   (READ_LAT),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_we    (rsp_we),
      .rsp_err   (rsp_err),
      .rsp_data  (rsp_data),
      .wb_cyc    (wb_cyc),
      .wb_str    (wb_str),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_dat_o  (wb_dat_o),
      .wb_dat_i  (wb_dat_i),
      .wb_ack    (wb_ack),
      .busy      (busy)
   );

   // ---------------- check task ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- slave model and reference storage ----------------
   logic        ack_en = 1'b1;
   logic [31:0] slv_mem [256] = '{default: '0};
   logic [31:0] ref_mem [256] = '{default: '0};

   function automatic logic [31:0] mem_read(input bit use_ref, input logic [7:0] a);
      logic [15:0] sa;
      logic [15:0] sb;
      logic [31:0] v;
      sa = '0;
      sb = '0;
      case (a)
         ADDR_ID0: return ID0_VAL;
         ADDR_ID1: return ID1_VAL;
         ADDR_ID2: return ID2_VAL;
         ADDR_RESULT: begin
            for (int i = 0; i < 16; i++) begin
               v  = use_ref ? ref_mem[ADDR_FEATURE_BASE + 8'(i)]
                            : slv_mem[ADDR_FEATURE_BASE + 8'(i)];
               if (i < 8) sa = sa + v[15:0];
               else       sb = sb + v[15:0];
            end
            return {sb, sa};
         end
         default: return use_ref ? ref_mem[a] : slv_mem[a];
      endcase
   endfunction

   assign wb_ack = wb_cyc && wb_str && wb_we && ack_en;

   always @(posedge clk) begin
      if (wb_cyc && wb_str && wb_we && ack_en) slv_mem[wb_addr] <= wb_dat_o;
      if (wb_cyc && wb_str && !wb_we) wb_dat_i <= mem_read(1'b0, wb_addr);
   end

   // ---------------- scoreboard queues ----------------
   // exp_q : {we, err, data}
   // bus_q : {we, addr, data, strobe_len[7:0]}
   logic [33:0] exp_q[$];
   logic [48:0] bus_q[$];
   logic        mon_en = 1'b0;

   // ---------------- monitor ----------------
   logic        cyc_prev = 1'b0;
   int          run_len  = 0;
   logic [48:0] cur_bus  = '0;
   logic [33:0] cur_rsp;

   always @(negedge clk) begin
      if (!mon_en) begin
         exp_q.delete();
         bus_q.delete();
         cyc_prev = 1'b0;
         run_len  = 0;
      end else begin
         if (wb_cyc && !cyc_prev) begin
            if (bus_q.size() == 0) begin
               check_eq("bus_extra_cyc", wb_cyc, 1'b0);
            end else begin
               cur_bus = bus_q.pop_front();
               check_eq("bus_we", wb_we, cur_bus[48]);
               check_eq("bus_addr", wb_addr, cur_bus[47:40]);
               if (cur_bus[48]) check_eq("bus_dat", wb_dat_o, cur_bus[39:8]);
            end
            run_len = 0;
         end
         if (wb_cyc) begin
            run_len++;
            check_eq("bus_str", wb_str, 1'b1);
         end else begin
            check_eq("idle_str_we", {wb_str, wb_we}, 2'b00);
         end
         if (!wb_cyc && cyc_prev) begin
            check_eq("strobe_len", run_len, cur_bus[7:0]);
            check_eq("rsp_in_gap", rsp_valid, 1'b1);
         end
         cyc_prev = wb_cyc;
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("rsp_extra", rsp_valid, 1'b0);
            end else begin
               cur_rsp = exp_q.pop_front();
               check_eq("rsp_we", rsp_we, cur_rsp[33]);
               check_eq("rsp_err", rsp_err, cur_rsp[32]);
               check_eq("rsp_data", rsp_data, cur_rsp[31:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_cmd(input logic we, input logic [7:0] addr,
                           input logic [31:0] data);
      int waited;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = addr;
      cmd_data  = data;
      waited    = 0;
      while (!cmd_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check_eq("push_ready_wait", cmd_ready, 1'b1);
      if (cmd_ready) begin
         @(posedge clk);
         if (we) begin
            if (ack_en) ref_mem[addr] = data;
            exp_q.push_back({1'b1, !ack_en, 32'h0});
            bus_q.push_back({1'b1, addr, data, ack_en ? 8'd1 : 8'(TIMEOUT)});
         end else begin
            exp_q.push_back({1'b0, 1'b0, mem_read(1'b1, addr)});
            bus_q.push_back({1'b0, addr, data, 8'(READ_LAT + 1)});
         end
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_busy", busy, 1'b0);
      check_eq("drain_rsp_left", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_cmd_ready", cmd_ready, 1'b1);
      check_eq("rst_bus", {wb_cyc, wb_str, wb_we, wb_addr, wb_dat_o}, '0);
      check_eq("rst_rsp", {rsp_valid, rsp_we, rsp_err, rsp_data}, '0);
      check_eq("rst_busy", busy, 1'b0);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // write with immediate ack, then bus address/data hold when idle
      push_cmd(1'b1, ADDR_W0_LO, 32'hDEAD_BEEF);
      wait_idle();
      check_eq("hold_addr", wb_addr, ADDR_W0_LO);
      check_eq("hold_dat", wb_dat_o, 32'hDEAD_BEEF);
      check_eq("hold_rsp_we", rsp_we, 1'b1);

      // ID read through the registered slave
      push_cmd(1'b0, ADDR_ID0, 32'h0);
      wait_idle();
      check_eq("hold_rsp_data", rsp_data, ID0_VAL);

      // write timeout, and FIFO filling while the timed-out write is on the bus
      ack_en = 1'b0;
      push_cmd(1'b1, ADDR_W0_HI, 32'h1234_5678);
      n = 0;
      while (!wb_cyc && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("to_cyc_start", wb_cyc, 1'b1);
      push_cmd(1'b0, ADDR_ID1, 32'h0);
      push_cmd(1'b0, ADDR_ID2, 32'h0);
      push_cmd(1'b0, ADDR_W0_HI, 32'h0);
      push_cmd(1'b0, ADDR_W0_LO, 32'h0);
      check_eq("full_cmd_ready", cmd_ready, 1'b0);
      check_eq("full_busy", busy, 1'b1);
      push_cmd(1'b0, ADDR_ID0, 32'h0);
      wait_idle();
      ack_en = 1'b1;

      // features then RESULT
      push_cmd(1'b1, ADDR_FEATURE_BASE, 32'h1111_1111);
      push_cmd(1'b1, ADDR_FEATURE_BASE + 8'd8, 32'h2222_2222);
      push_cmd(1'b0, ADDR_RESULT, 32'h0);
      wait_idle();
      check_eq("result_direct", rsp_data, 32'h2222_1111);

      // random mix of weight/feature writes and reads
      for (int i = 0; i < 12; i++) begin
         int          kind;
         logic [7:0]  a;
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            a = ADDR_FEATURE_BASE + 8'($urandom_range(0, 15));
            push_cmd(1'b1, a, $urandom);
         end else if (kind == 1) begin
            a = ADDR_W0_LO + 8'($urandom_range(0, 5));
            push_cmd(1'b1, a, $urandom);
         end else begin
            a = ADDR_FEATURE_BASE + 8'($urandom_range(0, 15));
            push_cmd(1'b0, a, $urandom);
         end
      end
      push_cmd(1'b0, ADDR_RESULT, 32'h0);
      wait_idle();

      // reset during a read with two commands still queued
      push_cmd(1'b0, ADDR_ID0, 32'h0);
      push_cmd(1'b0, ADDR_ID1, 32'h0);
      push_cmd(1'b0, ADDR_ID2, 32'h0);
      check_eq("pre_rst_rd", {wb_cyc, wb_we}, 2'b10);
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      check_eq("mid_rst_bus", {wb_cyc, wb_str, wb_we}, 3'b000);
      check_eq("mid_rst_rsp", rsp_valid, 1'b0);
      check_eq("mid_rst_ready", cmd_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("in_rst_rsp", rsp_valid, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_ready", cmd_ready, 1'b1);
      check_eq("post_rst_busy", busy, 1'b0);
      mon_en = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("post_rst_quiet", {busy, wb_cyc}, 2'b00);

      // recovery after reset
      push_cmd(1'b1, ADDR_W1_MID, 32'hCAFE_F00D);
      push_cmd(1'b0, ADDR_W1_MID, 32'h0);
      wait_idle();
      check_eq("recover_rd", rsp_data, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
